// File: rtl/vga_timing.sv
// vga_timing: VGA scan counters with pixel-rate divider, registered sync/rgb output stage and frame tick
module vga_timing #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   PIX_DIV   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] rgb_in,
  output logic [9:0] row,
  output logic [9:0] col,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic [2:0] rgb_out,
  output logic       frame_tick
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIX_DIV < 1) begin : g_bad_params
    $error("vga_timing: totals must fit 10-bit counters and PIX_DIV must be >= 1");
  end
  logic [DW-1:0] div_q, div_d;
  logic [9:0]    row_q, row_d, col_q, col_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, visible_q, visible_d, tick_q, tick_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          pix_en, line_end, frame_end, in_active, in_hsync, in_vsync;
  always_comb begin
    pix_en    = div_q == DW'(PIX_DIV - 1);
    line_end  = col_q == 10'(H_TOTAL - 1);
    frame_end = line_end && row_q == 10'(V_TOTAL - 1);
    in_active = col_q < 10'(H_VISIBLE) && row_q < 10'(V_VISIBLE);
    in_hsync  = col_q >= 10'(H_VISIBLE + H_FRONT) && col_q < 10'(H_VISIBLE + H_FRONT + H_SYNC);
    in_vsync  = row_q >= 10'(V_VISIBLE + V_FRONT) && row_q < 10'(V_VISIBLE + V_FRONT + V_SYNC);
    div_d     = pix_en ? '0 : div_q + DW'(1);
    col_d     = !pix_en ? col_q : line_end ? '0 : col_q + 10'd1;
    row_d     = !(pix_en && line_end) ? row_q : frame_end ? '0 : row_q + 10'd1;
    // output stage samples the pre-increment coordinates, hence one pixel of latency
    visible_d = pix_en ? in_active : visible_q;
    rgb_d     = pix_en ? (in_active ? rgb_in : 3'b000) : rgb_q;
    hsync_d   = pix_en ? (in_hsync ? SYNC_POL : ~SYNC_POL) : hsync_q;
    vsync_d   = pix_en ? (in_vsync ? SYNC_POL : ~SYNC_POL) : vsync_q;
    tick_d    = pix_en && frame_end;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      hsync_q   <= ~SYNC_POL;
      vsync_q   <= ~SYNC_POL;
      visible_q <= 1'b0;
      rgb_q     <= 3'b000;
      tick_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      row_q     <= row_d;
      col_q     <= col_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      visible_q <= visible_d;
      rgb_q     <= rgb_d;
      tick_q    <= tick_d;
    end
  end
  assign row        = row_q;
  assign col        = col_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign visible    = visible_q;
  assign rgb_out    = rgb_q;
  assign frame_tick = tick_q;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: default-timing vectors, PIX_DIV=1 line timing, and a randomized reduced-size frame model
module tb_vga_timing;
  logic clk, rst;
  logic [2:0] rgb_def, rgb_one, rgb_sm;
  logic [9:0] row_def, col_def, row_one, col_one, row_sm, col_sm;
  logic hs_def, vs_def, vis_def, tk_def, hs_one, vs_one, vis_one, tk_one, hs_sm, vs_sm, vis_sm, tk_sm;
  logic [2:0] rgbo_def, rgbo_one, rgbo_sm;
  int n_chk = 0, n_fail = 0;

  localparam int SD = 3, SHV = 20, SHF = 2, SHS = 3, SHB = 3, SVV = 6, SVF = 1, SVS = 2, SVB = 2;
  localparam int SHT = SHV + SHF + SHS + SHB, SVT = SVV + SVF + SVS + SVB;
  localparam logic SPOL = 1'b1;

  vga_timing u_def (.clock(clk), .reset(rst), .rgb_in(rgb_def), .row(row_def), .col(col_def),
    .hsync(hs_def), .vsync(vs_def), .visible(vis_def), .rgb_out(rgbo_def), .frame_tick(tk_def));
  vga_timing #(.PIX_DIV(1)) u_one (.clock(clk), .reset(rst), .rgb_in(rgb_one), .row(row_one), .col(col_one),
    .hsync(hs_one), .vsync(vs_one), .visible(vis_one), .rgb_out(rgbo_one), .frame_tick(tk_one));
  vga_timing #(.H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB), .V_VISIBLE(SVV), .V_FRONT(SVF),
    .V_SYNC(SVS), .V_BACK(SVB), .SYNC_POL(SPOL), .PIX_DIV(SD)) u_sm (.clock(clk), .reset(rst), .rgb_in(rgb_sm),
    .row(row_sm), .col(col_sm), .hsync(hs_sm), .vsync(vs_sm), .visible(vis_sm), .rgb_out(rgbo_sm), .frame_tick(tk_sm));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;
    logic [9:0] row, col;
    logic hs, vs, vis;
    logic [2:0] rgb;
  } vec_t;
  vec_t tbl[12];
  logic [2:0] samp[4096];

  function automatic logic [26:0] pk(logic [9:0] r, logic [9:0] c, logic h, logic v, logic vi, logic [2:0] g, logic t);
    return {r, c, h, v, vi, g, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [26:0] model_sm(int n);
    int k, p, pc, pr;
    logic vi, h, v, t;
    logic [2:0] g;
    k = n / SD;
    t = (n % SD == 0) && k > 0 && (k % (SHT * SVT) == 0);
    if (k == 0) return pk(10'd0, 10'd0, ~SPOL, ~SPOL, 1'b0, 3'b000, 1'b0);
    p  = k - 1;
    pc = p % SHT;
    pr = (p / SHT) % SVT;
    vi = pc < SHV && pr < SVV;
    g  = vi ? samp[p] : 3'b000;
    h  = (pc >= SHV + SHF && pc < SHV + SHF + SHS) ? SPOL : ~SPOL;
    v  = (pr >= SVV + SVF && pr < SVV + SVF + SVS) ? SPOL : ~SPOL;
    return pk(10'((k / SHT) % SVT), 10'(k % SHT), h, v, vi, g, t);
  endfunction

  initial begin
    int cyc, fe, low, f1, f2, ticks;
    logic prev;
    tbl[0]  = '{0,    10'd0, 10'd0,   1, 1, 0, 3'd0};
    tbl[1]  = '{1,    10'd0, 10'd0,   1, 1, 0, 3'd0};
    tbl[2]  = '{2,    10'd0, 10'd1,   1, 1, 1, 3'd5};
    tbl[3]  = '{3,    10'd0, 10'd1,   1, 1, 1, 3'd5};
    tbl[4]  = '{1280, 10'd0, 10'd640, 1, 1, 1, 3'd5};
    tbl[5]  = '{1282, 10'd0, 10'd641, 1, 1, 0, 3'd0};
    tbl[6]  = '{1312, 10'd0, 10'd656, 1, 1, 0, 3'd0};
    tbl[7]  = '{1314, 10'd0, 10'd657, 0, 1, 0, 3'd0};
    tbl[8]  = '{1504, 10'd0, 10'd752, 0, 1, 0, 3'd0};
    tbl[9]  = '{1506, 10'd0, 10'd753, 1, 1, 0, 3'd0};
    tbl[10] = '{1600, 10'd1, 10'd0,   1, 1, 0, 3'd0};
    tbl[11] = '{1602, 10'd1, 10'd1,   1, 1, 1, 3'd5};
    rgb_def = 3'b101;
    rgb_one = 3'b111;
    rgb_sm  = 3'b000;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 chk("reset_state", 32'(pk(row_def, col_def, hs_def, vs_def, vis_def, rgbo_def, tk_def)),
           32'(pk(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0)));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      while (cyc < tbl[i].n) begin
        @(posedge clk);
        cyc++;
        @(negedge clk);
      end
      chk($sformatf("vec%0d", i), 32'(pk(row_def, col_def, hs_def, vs_def, vis_def, rgbo_def, tk_def)),
          32'(pk(tbl[i].row, tbl[i].col, tbl[i].hs, tbl[i].vs, tbl[i].vis, tbl[i].rgb, 1'b0)));
    end
    low = 0;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      if (!hs_def) low++;
    end
    chk("hsync_low_per_line", 32'(low), 32'd192);
    for (int i = 0; i < 2000 && col_def != 10'd656; i++) @(negedge clk);
    fe = -1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (!hs_def && fe < 0) fe = j;
    end
    chk("hsync_fall_delay", 32'(fe), 32'd2);
    for (int i = 0; i < 2000 && col_def != 10'd300; i++) @(negedge clk);
    chk("pre_reset_col", 32'(col_def), 32'd300);
    rst = 1'b1;
    #1 chk("midline_reset", 32'(pk(row_def, col_def, hs_def, vs_def, vis_def, rgbo_def, tk_def)),
           32'(pk(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0)));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("col_after_1st_edge", 32'(col_def), 32'd0);
    @(negedge clk);
    chk("col_after_2nd_edge", 32'(col_def), 32'd1);
    f1 = -1;
    f2 = -1;
    low = 0;
    prev = hs_one;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (prev && !hs_one) begin
        if (f1 < 0) f1 = i;
        else if (f2 < 0) f2 = i;
      end
      if (f1 >= 0 && f2 < 0 && !hs_one) low++;
      prev = hs_one;
    end
    chk("div1_line_period", 32'(f2 - f1), 32'd800);
    chk("div1_hsync_low", 32'(low), 32'd96);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    ticks = 0;
    for (int c = 0; c < 3 * SHT * SVT * SD + 5; c++) begin
      chk("model_sm", 32'(pk(row_sm, col_sm, hs_sm, vs_sm, vis_sm, rgbo_sm, tk_sm)), 32'(model_sm(cyc)));
      if (tk_sm) ticks++;
      rgb_sm = 3'($urandom_range(0, 7));
      @(posedge clk);
      cyc++;
      if (cyc % SD == 0) samp[(cyc / SD - 1) % 4096] = rgb_sm;
      @(negedge clk);
    end
    chk("sm_frame_ticks", 32'(ticks), 32'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
